// File: rtl/vscale_dmem_bridge.sv
// Bridges the V-Scale pipeline data-memory port onto a valid/ready request bus
// with a separate response strobe. Faults misaligned or out-of-range accesses locally.
module vscale_dmem_bridge #(
  parameter logic [31:0] MEM_BYTES = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic        dmem_wait,
  output logic [31:0] dmem_rdata,
  output logic        dmem_badmem_e,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [3:0]  mem_req_wstrb,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic [2:0]  dbg_state_o
);

  // Bus handshake: a request transfers on a cycle where mem_req_valid and
  // mem_req_ready are both 1; valid depends on state only, and every request
  // field stays constant while valid is held without ready. mem_resp_valid is
  // a one-cycle strobe, honoured only while a request is outstanding (WAIT).
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] rdata_q, rdata_d;

  logic is_byte, is_half, is_word;
  logic req_bad;

  assign is_byte = (dmem_size == 3'd0);
  assign is_half = (dmem_size == 3'd1);
  assign is_word = !is_byte && !is_half;
  assign req_bad = (is_half && dmem_addr[0])
                || (is_word && (dmem_addr[1:0] != 2'b00))
                || (dmem_addr >= MEM_BYTES);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      size_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (dmem_en) begin
          addr_d = dmem_addr;
          wen_d  = dmem_wen;
          size_d = dmem_size;
          if (req_bad) begin
            state_d = S_ERR;
            rdata_d = '0;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          rdata_d = mem_resp_rdata;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [3:0] strb;

  always_comb begin
    strb = 4'b1111;
    case (size_q)
      3'd0:    strb = 4'b0001 << addr_q[1:0];
      3'd1:    strb = 4'b0011 << {addr_q[1], 1'b0};
      default: strb = 4'b1111;
    endcase
  end

  assign mem_req_valid = (state_q == S_ISSUE);
  assign mem_req_wen   = wen_q;
  assign mem_req_addr  = {addr_q[31:2], 2'b00};
  assign mem_req_wstrb = wen_q ? strb : 4'b0000;
  assign mem_req_wdata = dmem_wdata_delayed;

  assign dmem_wait     = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign dmem_badmem_e = (state_q == S_ERR);
  assign dmem_rdata    = rdata_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_vscale_dmem_bridge.sv
// Self-checking bench for vscale_dmem_bridge: directed scenarios plus randomized
// accesses compared against a transaction-level model of fault, strobe and timing rules.
module tb_vscale_dmem_bridge;

  localparam logic [31:0] MEM_BYTES = 32'h0001_0000;

  logic        clk;
  logic        reset_n;
  logic        dmem_en;
  logic        dmem_wen;
  logic [2:0]  dmem_size;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata_delayed;
  logic        dmem_wait;
  logic [31:0] dmem_rdata;
  logic        dmem_badmem_e;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [3:0]  mem_req_wstrb;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rdata = '0;

  vscale_dmem_bridge #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .dmem_en            (dmem_en),
    .dmem_wen           (dmem_wen),
    .dmem_size          (dmem_size),
    .dmem_addr          (dmem_addr),
    .dmem_wdata_delayed (dmem_wdata_delayed),
    .dmem_wait          (dmem_wait),
    .dmem_rdata         (dmem_rdata),
    .dmem_badmem_e      (dmem_badmem_e),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_wen        (mem_req_wen),
    .mem_req_addr       (mem_req_addr),
    .mem_req_wstrb      (mem_req_wstrb),
    .mem_req_wdata      (mem_req_wdata),
    .mem_resp_valid     (mem_resp_valid),
    .mem_resp_rdata     (mem_resp_rdata),
    .dbg_state_o        (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Reference model, expressed as plain arithmetic on the access rules
  function automatic bit model_bad(input logic [2:0] size, input logic [31:0] addr);
    int unsigned a;
    a = addr;
    if (a >= MEM_BYTES) return 1'b1;
    if (size == 3'd0) return 1'b0;
    if (size == 3'd1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [3:0] model_strb(input logic wen, input logic [2:0] size,
                                            input logic [31:0] addr);
    int unsigned lane;
    lane = addr % 4;
    if (!wen) return 4'd0;
    if (size == 3'd0) return 4'(1 << lane);
    if (size == 3'd1) return 4'(3 << ((lane / 2) * 2));
    return 4'd15;
  endfunction

  // Driver: presents one address phase, then plays the bus side with the given
  // ready and response delays. Ends at a sample point in DONE or ERR.
  task automatic do_access(input logic wen, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdat,
                           input int rdly, input int sdly, input bit junk);
    bit         bad;
    logic [3:0] strb;
    logic [31:0] waddr;
    int         n_wait;
    bad   = model_bad(size, addr);
    strb  = model_strb(wen, size, addr);
    waddr = addr & 32'hFFFF_FFFC;
    dmem_en = 1'b1;
    dmem_wen = wen;
    dmem_size = size;
    dmem_addr = addr;
    dmem_wdata_delayed = wdata;
    @(posedge clk); #1;
    dmem_en = 1'b0;
    if (bad) begin
      exp_rdata = '0;
      checks++;
      if (dmem_badmem_e !== 1'b1 || dmem_wait !== 1'b0 || mem_req_valid !== 1'b0 ||
          dmem_rdata !== 32'd0) begin
        errors++;
        $display("FAIL fault addr=%h size=%0d: badmem=%b wait=%b valid=%b rdata=%h, need 1 0 0 00000000",
                 addr, size, dmem_badmem_e, dmem_wait, mem_req_valid, dmem_rdata);
      end
    end else begin
      n_wait = 0;
      for (int i = 0; i <= rdly; i++) begin
        mem_req_ready = (i == rdly);
        if (junk) begin
          dmem_en = 1'($urandom_range(0, 1));
          dmem_addr = $urandom;
          dmem_wen = 1'($urandom_range(0, 1));
          dmem_size = 3'($urandom_range(0, 7));
          mem_resp_valid = 1'($urandom_range(0, 1));
          mem_resp_rdata = $urandom;
        end
        checks++;
        if ({mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wstrb, mem_req_wdata, dmem_badmem_e} !==
            {1'b1, wen, waddr, strb, wdata, 1'b0}) begin
          errors++;
          $display("FAIL issue addr=%h cyc=%0d: valid=%b wen=%b addr=%h strb=%b wdata=%h bad=%b, need 1 %b %h %b %h 0",
                   addr, i, mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wstrb, mem_req_wdata,
                   dmem_badmem_e, wen, waddr, strb, wdata);
        end
        n_wait += int'(dmem_wait);
        @(posedge clk); #1;
      end
      mem_req_ready = 1'b0;
      for (int j = 0; j <= sdly; j++) begin
        mem_resp_valid = (j == sdly);
        mem_resp_rdata = (j == sdly) ? rdat : $urandom;
        if (junk) begin
          dmem_en = 1'($urandom_range(0, 1));
          dmem_addr = $urandom;
        end
        checks++;
        if (mem_req_valid !== 1'b0 || dmem_badmem_e !== 1'b0) begin
          errors++;
          $display("FAIL wait addr=%h cyc=%0d: valid=%b badmem=%b, need 0 0",
                   addr, j, mem_req_valid, dmem_badmem_e);
        end
        n_wait += int'(dmem_wait);
        @(posedge clk); #1;
      end
      mem_resp_valid = 1'b0;
      dmem_en = 1'b0;
      exp_rdata = rdat;
      checks++;
      if (dmem_wait !== 1'b0 || dmem_rdata !== rdat || dmem_badmem_e !== 1'b0) begin
        errors++;
        $display("FAIL done addr=%h: wait=%b rdata=%h badmem=%b, need 0 %h 0",
                 addr, dmem_wait, dmem_rdata, dmem_badmem_e, rdat);
      end
      checks++;
      if (n_wait != rdly + sdly + 2) begin
        errors++;
        $display("FAIL wait_len addr=%h: %0d cycles, need %0d", addr, n_wait, rdly + sdly + 2);
      end
    end
  endtask

  // One cycle with no request; stray responses must be ignored
  task automatic idle_cycle();
    dmem_en = 1'b0;
    mem_resp_valid = 1'($urandom_range(0, 1));
    mem_resp_rdata = $urandom;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    checks++;
    if (dmem_wait !== 1'b0 || mem_req_valid !== 1'b0 || dmem_badmem_e !== 1'b0 ||
        dmem_rdata !== exp_rdata) begin
      errors++;
      $display("FAIL idle: wait=%b valid=%b badmem=%b rdata=%h, need 0 0 0 %h",
               dmem_wait, mem_req_valid, dmem_badmem_e, dmem_rdata, exp_rdata);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    dmem_en = 1'b0; dmem_wen = 1'b0; dmem_size = 3'd0; dmem_addr = '0;
    dmem_wdata_delayed = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dmem_wait !== 1'b0 || mem_req_valid !== 1'b0 || dmem_badmem_e !== 1'b0 ||
        dmem_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset: wait=%b valid=%b badmem=%b rdata=%h, need all 0",
               dmem_wait, mem_req_valid, dmem_badmem_e, dmem_rdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    exp_rdata = '0;
    idle_cycle();
  endtask

  task automatic test_word_load();
    do_access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
    idle_cycle();
  endtask

  task automatic test_byte_store();
    do_access(1'b1, 3'd0, 32'h203, 32'h5A5A_5A5A, 32'h1234_5678, 0, 0, 1'b0);
    do_access(1'b1, 3'd1, 32'h302, 32'hA5A5_A5A5, 32'h0BAD_F00D, 1, 0, 1'b0);
    idle_cycle();
  endtask

  task automatic test_backpressure();
    do_access(1'b1, 3'd2, 32'h400, 32'hCAFE_F00D, 32'h7777_0000, 3, 1, 1'b1);
    idle_cycle();
  endtask

  task automatic test_faults();
    do_access(1'b0, 3'd1, 32'h101, 32'h0, 32'h0, 0, 0, 1'b0);
    do_access(1'b0, 3'd2, 32'h1_0000, 32'h0, 32'h0, 0, 0, 1'b0);
    idle_cycle();
    do_access(1'b0, 3'd2, MEM_BYTES - 32'd4, 32'h0, 32'h0F0F_1234, 0, 0, 1'b0);
    do_access(1'b0, 3'd0, MEM_BYTES, 32'h0, 32'h0, 0, 0, 1'b0);
    do_access(1'b0, 3'd7, 32'h22, 32'h0, 32'h0, 0, 0, 1'b0);
    idle_cycle();
  endtask

  task automatic test_reset_in_wait();
    do_access(1'b0, 3'd2, 32'h80, 32'h0, 32'h1357_9BDF, 0, 0, 1'b0);
    dmem_en = 1'b1; dmem_wen = 1'b0; dmem_size = 3'd2; dmem_addr = 32'h40;
    @(posedge clk); #1;
    dmem_en = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    exp_rdata = '0;
    checks++;
    if (dmem_wait !== 1'b0 || mem_req_valid !== 1'b0 || dmem_badmem_e !== 1'b0 ||
        dmem_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_in_wait: wait=%b valid=%b badmem=%b rdata=%h, need all 0",
               dmem_wait, mem_req_valid, dmem_badmem_e, dmem_rdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hFFFF_0001;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    checks++;
    if (dmem_rdata !== 32'd0 || dmem_wait !== 1'b0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_resp: rdata=%h wait=%b valid=%b, need 00000000 0 0",
               dmem_rdata, dmem_wait, mem_req_valid);
    end
    do_access(1'b0, 3'd2, 32'h44, 32'h0, 32'h2468_ACE0, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 3'd2, 32'h10, 32'h0, 32'hABCD_0010, 0, 0, 1'b0);
    do_access(1'b1, 3'd2, 32'h14, 32'h1111_2222, 32'h0, 0, 0, 1'b0);
    do_access(1'b0, 3'd1, 32'h15, 32'h0, 32'h0, 0, 0, 1'b0);
    do_access(1'b0, 3'd1, 32'h16, 32'h0, 32'h3333_4444, 0, 2, 1'b0);
    idle_cycle();
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) addr = MEM_BYTES + $urandom_range(0, 64);
      else addr = $urandom_range(0, MEM_BYTES - 1);
      do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_backpressure();
    test_faults();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vscale_dmem_bridge.md
VSCALE_DMEM_BRIDGE -- requirements
Module: vscale_dmem_bridge

Interface
REQ-001 SHALL have parameter: MEM_BYTES, 32'h0001_0000, size of the decoded data region in bytes; valid addresses are [0, MEM_BYTES).
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  sole clock; all state changes on its rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- dmem_en  in  1  pipeline address-phase request.
- dmem_wen  in  1  1 = store, 0 = load.
- dmem_size  in  3  0 byte, 1 half, 2 word; other values are treated as word.
- dmem_addr  in  32  byte address, valid in the address phase.
- dmem_wdata_delayed  in  32  store data, byte-replicated by the pipeline, valid during the data phase.
- dmem_wait  out  1  data phase not complete; the pipeline holds.
- dmem_rdata  out  32  load data for the completing data phase.
- dmem_badmem_e  out  1  the completing data phase faulted.
- mem_req_valid  out  1  bus request.
- mem_req_ready  in  1  bus accepts the request.
- mem_req_wen  out  1  bus write.
- mem_req_addr  out  32  word address: {addr[31:2], 2'b00}.
- mem_req_wstrb  out  4  byte enables; 4'b0000 for loads.
- mem_req_wdata  out  32  equals dmem_wdata_delayed.
- mem_resp_valid  in  1  bus response; asserted at least 1 cycle after request acceptance.
- mem_resp_rdata  in  32  bus read data.

Function
REQ-003 SHALL implement an FSM with states IDLE, ISSUE, WAIT, DONE and ERR.
REQ-004 SHALL accept an address phase when dmem_en=1 in IDLE, DONE or ERR. On acceptance it latches addr, wen and size.
REQ-005 SHALL ignore dmem_en in ISSUE and WAIT.
REQ-006 SHALL flag an accepted request as bad when it is misaligned or out of range:
- half with addr[0]=1;
- word with addr[1:0]!=0;
- addr >= MEM_BYTES.
REQ-007 SHALL transition from an accepting state:
- bad request -> ERR;
- good request -> ISSUE;
- no request -> IDLE.
REQ-008 SHALL in ISSUE drive mem_req_valid=1 with the latched wen, word address and strobes, and mem_req_wdata = dmem_wdata_delayed. It stays in ISSUE until mem_req_ready=1, then goes to WAIT.
REQ-009 SHALL hold all mem_req_* outputs stable while mem_req_valid=1 and mem_req_ready=0.
REQ-010 SHALL derive mem_req_wstrb for stores:
- byte: 4'b0001 << addr[1:0];
- half: 4'b0011 << {addr[1],1'b0};
- word: 4'b1111.
REQ-011 SHALL in WAIT, on mem_resp_valid=1, register mem_resp_rdata into rdata_q and go to DONE. mem_resp_valid is ignored in every other state.
REQ-012 SHALL drive dmem_wait=1 in ISSUE and WAIT, and 0 in IDLE, DONE and ERR.
REQ-013 SHALL drive dmem_rdata = rdata_q at all times. rdata_q is loaded only per REQ-011 and cleared to 0 on entry to ERR. The bridge does no shifting or extension of load data.
REQ-014 SHALL drive dmem_badmem_e=1 only in ERR. ERR lasts exactly one cycle unless a new request is accepted into ERR.
REQ-015 SHALL not assert mem_req_valid for a bad request.
REQ-016 SHALL have good-access timing as follows, with address phase in cycle A and ready/resp at their earliest:
- A+1 ISSUE, accepted;
- A+2 WAIT, resp;
- A+3 DONE, dmem_wait=0.
REQ-017 SHALL support back-to-back requests: an address phase presented in DONE or ERR is accepted in the same cycle the previous data phase completes.
REQ-018 SHALL treat mem_req_valid as combinational from state only; it must not depend on mem_req_ready.

Reset
REQ-019 SHALL on reset_n=0 immediately force:
- state IDLE;
- rdata_q, latched addr, wen and size all 0;
- dmem_wait, dmem_badmem_e and mem_req_valid all 0.
REQ-020 SHALL on reset mid-transaction drop the outstanding request and discard any later mem_resp_valid that arrives while in IDLE.

Verification
REQ-021 Word load: addr 0x100, ready and resp immediate, rdata 0xDEADBEEF -> one request with wstrb 0000 and addr 0x100; dmem_wait high for 2 cycles; DONE with dmem_rdata 0xDEADBEEF and badmem 0.
REQ-022 Byte store: addr 0x203, wdata 0x5A5A5A5A -> mem_req_wstrb 1000, mem_req_addr 0x200, mem_req_wdata 0x5A5A5A5A, mem_req_wen 1.
REQ-023 Backpressure: ready low 3 cycles, then resp after 2 more -> request fields stable for 4 cycles; dmem_wait high 6 cycles total.
REQ-024 Faults: half at 0x101, then word at 0x10000 back-to-back -> no mem_req_valid; dmem_badmem_e high for 2 consecutive cycles; dmem_rdata 0; dmem_wait 0 throughout.
REQ-025 Reset in WAIT: reset_n pulsed low, then a resp arrives -> outputs 0 immediately; the resp is ignored and the FSM stays in IDLE.
REQ-026 Back-to-back: load 0x10 completes in DONE while dmem_en for a store to 0x14 is present -> the store is accepted that cycle and ISSUE occurs in the next cycle.
